// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO; frames go out back-to-back while data is queued.
// Optional even-parity bit (8E1) when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic             clock,
  input  logic             reset_rtl,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             uart_txd,
  output logic             tx_busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                txd_d, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic                push_c, pop_c, empty_c, baud_end_c;
  logic [CNT_W-1:0]    count_nxt_c;
  logic [7:0]          head_c;

  assign push_c     = tx_valid & tx_ready;
  assign empty_c    = (fifo_count == '0);
  assign baud_end_c = (baud_q == BAUD_LAST);
  assign head_c     = mem[rptr];

  always_comb begin
    count_nxt_c = fifo_count;
    if (push_c && !pop_c)      count_nxt_c = fifo_count + CNT_W'(1);
    else if (!push_c && pop_c) count_nxt_c = fifo_count - CNT_W'(1);
  end

  // FIFO storage has no reset; only pointers and count are cleared
  always_ff @(posedge clock) begin
    if (push_c) mem[wptr] <= tx_data;
  end

  always_ff @(posedge clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      tx_ready   <= 1'b1;
    end else begin
      if (push_c) wptr <= wptr + PTR_W'(1);
      if (pop_c)  rptr <= rptr + PTR_W'(1);
      fifo_count <= count_nxt_c;
      tx_ready   <= (count_nxt_c != CNT_FULL);
    end
  end

  always_ff @(posedge clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      uart_txd <= txd_d;
      tx_busy  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = uart_txd;
    busy_d  = tx_busy;
    pop_c   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shreg_d = head_c;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head_c;
`endif
        end
      end
      S_START: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shreg_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      // LSB first: shift right and present the next bit each cell
      S_DATA: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = S_PARITY;
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            txd_d   = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end_c) begin
          baud_d  = '0;
          txd_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      // Chain straight into the next start bit when more data is queued
      S_STOP: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (!empty_c) begin
            pop_c   = 1'b1;
            shreg_d = head_c;
            txd_d   = 1'b0;
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head_c;
`endif
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushes queue expected bytes, a line receiver checks frames.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NCELLS     = 11;
  localparam int unsigned EXP_FRAMES = 12;
`else
  localparam int unsigned NCELLS     = 10;
  localparam int unsigned EXP_FRAMES = 10;
`endif
  localparam int unsigned FRAME_CYC = CPB * NCELLS;

  logic          clock = 1'b0;
  logic          reset_rtl = 1'b0;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, uart_txd, tx_busy;
  logic [CW-1:0] fifo_count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock(clock), .reset_rtl(reset_rtl), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_txd(uart_txd), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int push_cyc = 0;
  int rx_ok = 0;
  logic [7:0] exp_q[$];
  int fall_q[$];
  bit mon_busy = 1'b0;
  bit abort_flag = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Receiver model: detect start bit, sample every cell centre
  initial begin : monitor
    logic [NCELLS-1:0] cells;
    logic [7:0] exp, got;
    forever begin
      @(negedge clock);
      if (reset_rtl && uart_txd === 1'b0) begin
        mon_busy = 1'b1;
        fall_q.push_back(cyc);
        repeat (CPB/2 - 1) @(negedge clock);
        cells[0] = uart_txd;
        for (int i = 1; i < int'(NCELLS); i++) begin
          repeat (CPB) @(negedge clock);
          cells[i] = uart_txd;
        end
        got = cells[8:1];
        if (abort_flag) begin
          abort_flag = 1'b0;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_frame", int'(got), -1);
        end else begin
          exp = exp_q.pop_front();
          chk("start_bit", int'(cells[0]), 0);
          chk("rx_data", int'(got), int'(exp));
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", int'(cells[9]), int'(^exp));
`endif
          chk("stop_bit", int'(cells[NCELLS-1]), 1);
          if (got == exp) rx_ok++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    bit ok;
    int n;
    tx_data  = b;
    tx_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 2000) begin
      @(negedge clock);
      ok = tx_ready;
      @(posedge clock);
      n++;
    end
    #1;
    tx_valid = 1'b0;
    push_cyc = cyc;
    if (ok) exp_q.push_back(b);
    else chk("push_timeout", 1, 0);
  endtask

  task automatic wait_fall(input int n);
    int k = 0;
    while (fall_q.size() < n && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (fall_q.size() < n) chk("fall_timeout", fall_q.size(), n);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < 8000) begin
      @(negedge clock);
      k++;
    end
    chk(name, int'(exp_q.size() != 0 || mon_busy), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic busy_len(input string name);
    int k = 0;
    while (tx_busy && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (fall_q.size() > 0) chk(name, cyc - fall_q[0], int'(FRAME_CYC));
  endtask

  initial begin : main
    logic [7:0] fill [6];
    int bad;
    fill = '{8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'hC3};

    // Reset and idle line
    #100;
    reset_rtl = 1'b1;
    @(negedge clock);
    chk("rst_txd", int'(uart_txd), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_count", int'(fifo_count), 0);
    bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if (uart_txd !== 1'b1) bad++;
    end
    chk("idle_line", bad, 0);
    @(posedge clock);
    #1;

    // Single byte 0x41: latency and frame length
    fall_q.delete();
    push(8'h41);
    wait_fall(1);
    if (fall_q.size() > 0) chk("latency", fall_q[0], push_cyc + 1);
    chk("busy_set", int'(tx_busy), 1);
    busy_len("frame_len");
    wait_idle("drain_41");

    // "Hi" back-to-back
    fall_q.delete();
    push(8'h48);
    push(8'h69);
    @(negedge clock);
    chk("count_after_hi", int'(fifo_count), 1);
    wait_fall(2);
    chk("count_after_pop2", int'(fifo_count), 0);
    if (fall_q.size() > 1) chk("frame_gap", fall_q[1] - fall_q[0], int'(FRAME_CYC));
    wait_idle("drain_hi");

    // Fill the FIFO while the line is busy
    for (int i = 0; i < 5; i++) push(fill[i]);
    @(negedge clock);
    chk("full_ready", int'(tx_ready), 0);
    chk("full_count", int'(fifo_count), int'(DEPTH));
    @(posedge clock);
    #1;
    push(fill[5]);
    wait_idle("drain_fill");

    // Reset in the middle of a frame with bytes queued
    fall_q.delete();
    push(8'hA5);
    push(8'h55);
    push(8'h0F);
    wait_fall(1);
    repeat (CPB*3 + 4) @(posedge clock);
    #3;
    abort_flag = 1'b1;
    reset_rtl = 1'b0;
    #1;
    chk("abort_txd", int'(uart_txd), 1);
    chk("abort_count", int'(fifo_count), 0);
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_ready", int'(tx_ready), 1);
    exp_q.delete();
    #20;
    reset_rtl = 1'b1;
    wait_idle("abort_settle");
    push(8'h3C);
    wait_idle("drain_3c");

`ifdef UART_TX_PARITY_EN
    fall_q.delete();
    push(8'h07);
    wait_fall(1);
    busy_len("parity_frame_len");
    wait_idle("drain_07");
    push(8'h03);
    wait_idle("drain_03");
`endif

    chk("frames_rx", rx_ok, int'(EXP_FRAMES));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter with a small input FIFO. It is the transmit-side counterpart of the 8N1 receiver at 230400 baud from a 100 MHz clock.
- It serialises bytes pushed by a processor-side producer onto a single TXD line.
- It lets the producer queue several bytes ahead of the line.
- Frames go out back-to-back with no idle gap while the FIFO holds data.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (100000000/230400, integer division); legal range >= 2.
- FIFO_DEPTH, 16, number of FIFO entries; power of 2, >= 2.
- CNT_W, 5, width of fifo_count; must hold FIFO_DEPTH (clog2(FIFO_DEPTH)+1).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_rtl  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_ready  out  1  FIFO can accept a byte; equals !full.
- uart_txd  out  1  serial output; idle high; driven by a register.
- tx_busy  out  1  high while a frame is on the line (any state other than IDLE).
- fifo_count  out  CNT_W  number of bytes currently queued (excluding the byte being shifted).

Behaviour:
- Reset (reset_rtl=0, asynchronous) forces:
  - uart_txd=1, tx_busy=0, fifo_count=0, tx_ready=1
  - state=IDLE, baud counter=0, bit index=0
  - FIFO read and write pointers=0
- Reset while a frame is on the line aborts the frame: uart_txd returns high immediately and the queued bytes are discarded.
- Push:
  - A push occurs on any rising edge with tx_valid=1 and tx_ready=1. tx_data is written at the write pointer, which then increments modulo FIFO_DEPTH.
  - tx_valid while full is ignored and nothing is written. The producer must hold tx_data and tx_valid until the push occurs.
- Pop: performed only by the FSM, as described below. The read pointer increments modulo FIFO_DEPTH.
- Push and pop on the same edge: fifo_count is unchanged. Both pointers advance.
- Full: fifo_count==FIFO_DEPTH. A push is refused even if a pop happens on the same edge.
- Baud counter: runs 0..CLKS_PER_BIT-1. Every bit cell lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_txd=1. If the FIFO is not empty, pop into the shift register, set uart_txd<=0 and go to START. The counter is 0 on entry.
  - START: at counter==CLKS_PER_BIT-1, clear the counter, drive bit 0 and go to DATA.
  - DATA: bits are sent LSB first. At the end of each cell, drive the next bit. After bit 7's cell, drive uart_txd<=1 and go to STOP.
  - STOP: one high cell. At the end of the cell:
    - FIFO not empty: pop, uart_txd<=0, go to START. There is no idle cycle between frames.
    - FIFO empty: go to IDLE.
- Latency: if a byte is pushed at edge k into an empty FIFO with the FSM in IDLE, uart_txd falls at edge k+1.
- Frame length: 10*CLKS_PER_BIT cycles, start edge to end of stop.
- tx_busy is registered. It is 1 from the edge that enters START until the edge that returns to IDLE.
- fifo_count decrements on the edge of each pop.
- Counter, bit index and pointer arithmetic wrap naturally at their widths. Out-of-range state values recover to IDLE with uart_txd=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for one CLKS_PER_BIT cell. The frame becomes 11*CLKS_PER_BIT cycles (8E1).
- Undefined: the PARITY state and its logic are not compiled in. The frame is 8N1 at 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset held low 100 ns, then released -> uart_txd=1, tx_busy=0, tx_ready=1, fifo_count=0. uart_txd stays 1 for 1000 cycles with no push.
- CLKS_PER_BIT=8, push 0x41 -> uart_txd falls 1 cycle after the push. Sampled at cell centres the line reads 0,1,0,0,0,0,0,1,0,1. tx_busy drops 80 cycles after the fall.
- CLKS_PER_BIT=8, push 'H','i' on consecutive cycles -> the second start bit begins exactly 80 cycles after the first. fifo_count reads 1 then 0 after the second pop. A receiver model decodes "Hi".
- FIFO_DEPTH=4, 6 pushes offered with the line busy -> the first byte pops, 4 queue, and tx_ready=0 with fifo_count=4. Excess tx_valid is held until ready returns. All 6 bytes go out in order.
- Assert reset_rtl mid-DATA of byte 0xA5 with 2 bytes queued -> uart_txd=1 asynchronously and fifo_count=0. After release a new push of 0x3C transmits correctly.
- UART_TX_PARITY_EN defined, push 0x07 -> parity cell=1 and the frame is 88 cycles at CLKS_PER_BIT=8. Push 0x03 -> parity cell=0.
